// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types, constants and CRC-8 helper for the UART
// transmitter arbiter. Optional feature macro: UART_ARB_CRC_EN adds the
// CRC state encoding used when a CRC byte trails every completed frame.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef UART_ARB_CRC_EN
    ST_GUARD = 3'd3,
    ST_CRC   = 3'd4
`else
    ST_GUARD = 3'd3
`endif
  } arb_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // CRC-8, MSB-first: fold one byte into the running remainder.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_arb_rr.sv
// uart_arb_rr: combinational round-robin picker. Scans the valid vector
// starting one past the pointer (wrapping) and returns the first hit as a
// one-hot grant plus its index.
module uart_arb_rr #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] win_grant,
  output logic [IDXW-1:0]    win_idx,
  output logic               win_any
);

  logic [IDXW-1:0] cand_s;

  // First valid requester after the pointer wins; the pointer itself is checked last.
  always_comb begin
    win_grant = {NUM_REQ{1'b0}};
    win_idx   = {IDXW{1'b0}};
    win_any   = 1'b0;
    cand_s    = {IDXW{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDXW'((int'(ptr) + i) % NUM_REQ);
      if (!win_any && req_valid[cand_s]) begin
        win_any           = 1'b1;
        win_idx           = cand_s;
        win_grant[cand_s] = 1'b1;
      end else begin
        // an earlier candidate already won, or this one is idle
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter between NUM_REQ frame
// sources. Frame-granular round robin; the owner keeps the line (and the
// RS485 driver enable) until its last byte completes plus a guard gap.
// A requester that withholds its next byte for STALL_CLKS clocks loses
// the frame (o_Abort pulse). Optional feature macro: UART_ARB_CRC_EN
// appends a CRC-8 byte after the last byte of every non-aborted frame.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GUARD_CLKS = 16,
  parameter int STALL_CLKS = 1024
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Data,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_DE,
  output logic                   o_Busy,
  output logic                   o_Abort
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW   = $clog2(GUARD_CLKS + 1);
  localparam int SW   = $clog2(STALL_CLKS + 1);

  arb_state_t           state_r;
  logic [IDXW-1:0]      ptr_r;
  logic [NUM_REQ-1:0]   win_grant_s;
  logic [IDXW-1:0]      win_idx_s;
  logic                 win_any_s;
  logic                 done_d_r;
  logic                 done_rise_s;
  logic                 last_r;
  logic                 xfer_s;
  logic [7:0]           sel_data_s;
  logic                 sel_last_s;
  logic [GW-1:0]        guard_cnt_r;
  logic [SW-1:0]        stall_cnt_r;
`ifdef UART_ARB_CRC_EN
  logic [7:0]           crc_r;
  logic                 crc_sent_r;
`endif

  uart_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr (
    .req_valid (i_Req_Valid),
    .ptr       (ptr_r),
    .win_grant (win_grant_s),
    .win_idx   (win_idx_s),
    .win_any   (win_any_s)
  );

  // The pointer always holds the current owner's index while a grant is live.
  assign sel_data_s  = i_Req_Data[{ptr_r, 3'b000} +: 8];
  assign sel_last_s  = i_Req_Last[ptr_r];
  assign done_rise_s = i_Tx_Done & ~done_d_r;
  assign xfer_s      = |(i_Req_Valid & o_Req_Ready);

  // Ready goes only to the owner, and only while the transmitter is free.
  always_comb begin
    if ((state_r == ST_SEND) && !i_Tx_Active) begin
      o_Req_Ready = o_Grant;
    end else begin
      o_Req_Ready = {NUM_REQ{1'b0}};
    end
  end

  // Arbitration FSM with registered transmitter, driver-enable and status outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= IDXW'(NUM_REQ - 1);
      o_Grant     <= {NUM_REQ{1'b0}};
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= 8'h00;
      o_DE        <= 1'b0;
      o_Busy      <= 1'b0;
      o_Abort     <= 1'b0;
      done_d_r    <= 1'b0;
      last_r      <= 1'b0;
      guard_cnt_r <= {GW{1'b0}};
      stall_cnt_r <= {SW{1'b0}};
`ifdef UART_ARB_CRC_EN
      crc_r       <= CRC8_INIT;
      crc_sent_r  <= 1'b0;
`endif
    end else begin
      o_Tx_DV  <= 1'b0;
      o_Abort  <= 1'b0;
      done_d_r <= i_Tx_Done;
      case (state_r)
        ST_IDLE: begin
          if (win_any_s) begin
            o_Grant     <= win_grant_s;
            ptr_r       <= win_idx_s;
            o_DE        <= 1'b1;
            o_Busy      <= 1'b1;
            last_r      <= 1'b0;
            stall_cnt_r <= {SW{1'b0}};
            guard_cnt_r <= {GW{1'b0}};
`ifdef UART_ARB_CRC_EN
            crc_r       <= CRC8_INIT;
`endif
            state_r     <= ST_SEND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (xfer_s) begin
            o_Tx_DV     <= 1'b1;
            o_Tx_Byte   <= sel_data_s;
            last_r      <= sel_last_s;
            stall_cnt_r <= {SW{1'b0}};
`ifdef UART_ARB_CRC_EN
            crc_r       <= crc8_update(crc_r, sel_data_s);
`endif
            state_r     <= ST_WAIT;
          end else if (stall_cnt_r >= SW'(STALL_CLKS - 1)) begin
            o_Abort     <= 1'b1;
            stall_cnt_r <= {SW{1'b0}};
            guard_cnt_r <= {GW{1'b0}};
            state_r     <= ST_GUARD;
          end else begin
            stall_cnt_r <= stall_cnt_r + SW'(1);
          end
        end
        ST_WAIT: begin
          // A done held high for several clocks advances the frame only once.
          if (done_rise_s) begin
            if (!last_r) begin
              state_r <= ST_SEND;
            end else begin
`ifdef UART_ARB_CRC_EN
              crc_sent_r  <= 1'b0;
              state_r     <= ST_CRC;
`else
              guard_cnt_r <= {GW{1'b0}};
              state_r     <= ST_GUARD;
`endif
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
`ifdef UART_ARB_CRC_EN
        ST_CRC: begin
          if (!crc_sent_r && !i_Tx_Active) begin
            o_Tx_DV    <= 1'b1;
            o_Tx_Byte  <= crc_r;
            crc_sent_r <= 1'b1;
          end else if (crc_sent_r && done_rise_s) begin
            guard_cnt_r <= {GW{1'b0}};
            state_r     <= ST_GUARD;
          end else begin
            state_r <= ST_CRC;
          end
        end
`endif
        ST_GUARD: begin
          if (guard_cnt_r >= GW'(GUARD_CLKS - 1)) begin
            o_Grant     <= {NUM_REQ{1'b0}};
            o_DE        <= 1'b0;
            o_Busy      <= 1'b0;
            guard_cnt_r <= {GW{1'b0}};
            state_r     <= ST_IDLE;
          end else begin
            guard_cnt_r <= guard_cnt_r + GW'(1);
          end
        end
        default: begin
          o_Grant <= {NUM_REQ{1'b0}};
          o_DE    <= 1'b0;
          o_Busy  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
// (NUM_REQ=4, GUARD_CLKS=16, STALL_CLKS=1024). Contains a transmitter model
// that stays active TX_LEN clocks per byte and holds done high 2 clocks.
// Honours UART_ARB_CRC_EN for the expected trailing CRC bytes.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int TX_LEN = 12;
`ifdef UART_ARB_CRC_EN
  localparam int CRC_EXTRA = 1;
`else
  localparam int CRC_EXTRA = 0;
`endif

  logic        i_Clock     = 1'b0;
  logic        i_Reset     = 1'b0;
  logic [3:0]  i_Req_Valid = 4'b0000;
  logic [31:0] i_Req_Data  = 32'h0;
  logic [3:0]  i_Req_Last  = 4'b0000;
  logic        i_Tx_Active = 1'b0;
  logic        i_Tx_Done   = 1'b0;
  logic [3:0]  o_Req_Ready;
  logic [3:0]  o_Grant;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        o_DE;
  logic        o_Busy;
  logic        o_Abort;

  int n_cmp = 0;
  int n_err = 0;

  // transmitter model state
  int         tx_cnt     = 0;
  int         done_hold  = 0;
  int         dv_count   = 0;
  int         done_count = 0;
  logic [7:0] tx_log [0:63];

  uart_tx_arbiter #(.NUM_REQ(4), .GUARD_CLKS(16), .STALL_CLKS(1024)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Req_Valid (i_Req_Valid),
    .i_Req_Data  (i_Req_Data),
    .i_Req_Last  (i_Req_Last),
    .o_Req_Ready (o_Req_Ready),
    .o_Grant     (o_Grant),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_DE        (o_DE),
    .o_Busy      (o_Busy),
    .o_Abort     (o_Abort)
  );

  always #5 i_Clock = ~i_Clock;

  // Transmitter model: reacts 1ns after each edge, logs every started byte.
  always @(posedge i_Clock) begin
    #1;
    i_Tx_Done = 1'b0;
    if (done_hold > 0) begin
      i_Tx_Done = 1'b1;
      done_hold = done_hold - 1;
    end
    if (o_Tx_DV) begin
      i_Tx_Active = 1'b1;
      tx_cnt      = TX_LEN;
      if (dv_count < 64) tx_log[dv_count] = o_Tx_Byte;
      dv_count = dv_count + 1;
    end else if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) begin
        i_Tx_Active = 1'b0;
        i_Tx_Done   = 1'b1;
        done_hold   = 1;
        done_count  = done_count + 1;
      end
    end
  end

  task automatic tick();
    @(posedge i_Clock);
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int k, input logic [7:0] d, input logic l, input string tag);
    int n;
    i_Req_Valid[k]         = 1'b1;
    i_Req_Data[8*k +: 8]   = d;
    i_Req_Last[k]          = l;
    n = 0;
    while (!o_Req_Ready[k] && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, {31'd0, o_Req_Ready[k]}, 32'd1);
    tick();
    chk({tag, "_dv"}, {31'd0, o_Tx_DV}, 32'd1);
    chk({tag, "_byte"}, {24'd0, o_Tx_Byte}, {24'd0, d});
    i_Req_Valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_Busy && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, o_Busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gbad, d0, dn0, dvb;

    // ---- reset state (checked between clock edges: asynchronous) ----
    #2 i_Reset = 1'b1;
    #1;
    chk("rst_grant", {28'd0, o_Grant}, 32'd0);
    chk("rst_ready", {28'd0, o_Req_Ready}, 32'd0);
    chk("rst_dv",    {31'd0, o_Tx_DV}, 32'd0);
    chk("rst_byte",  {24'd0, o_Tx_Byte}, 32'd0);
    chk("rst_de",    {31'd0, o_DE}, 32'd0);
    chk("rst_busy",  {31'd0, o_Busy}, 32'd0);
    chk("rst_abort", {31'd0, o_Abort}, 32'd0);
    tick();
    tick();
    i_Reset = 1'b0;

    // ---- T1: req0 frame {A5, 3C}; req3 pokes the same IDLE cycle, req0 wins ----
    d0  = dv_count;
    dn0 = done_count;
    i_Req_Valid[0] = 1'b1; i_Req_Data[7:0]   = 8'hA5; i_Req_Last[0] = 1'b0;
    i_Req_Valid[3] = 1'b1; i_Req_Data[31:24] = 8'hEE; i_Req_Last[3] = 1'b1;
    tick();
    chk("t1_grant", {28'd0, o_Grant}, 32'h1);
    chk("t1_de",    {31'd0, o_DE}, 32'd1);
    chk("t1_busy",  {31'd0, o_Busy}, 32'd1);
    chk("t1_dv_lat1", {31'd0, o_Tx_DV}, 32'd0);
    i_Req_Valid[3] = 1'b0;
    tick();
    chk("t1_dv_lat2", {31'd0, o_Tx_DV}, 32'd1);
    chk("t1_byte0",   {24'd0, o_Tx_Byte}, 32'hA5);
    tick();
    chk("t1_dv_pulse", {31'd0, o_Tx_DV}, 32'd0);
    send_byte(0, 8'h3C, 1'b1, "t1_b1");
    gbad = 0;
    n = 0;
    while (done_count < dn0 + 2 + CRC_EXTRA && n < 500) begin
      if (o_Grant !== 4'b0001 || o_DE !== 1'b1) gbad++;
      tick();
      n++;
    end
    chk("t1_done_seen", done_count, dn0 + 2 + CRC_EXTRA);
    n = 0;
    while (o_DE && n < 100) begin
      if (o_Grant !== 4'b0001) gbad++;
      tick();
      n++;
    end
    chk("t1_grant_held", gbad, 32'd0);
    chk("t1_guard_len", n, 32'd17);
    chk("t1_grant_rel", {28'd0, o_Grant}, 32'd0);
    chk("t1_busy_rel",  {31'd0, o_Busy}, 32'd0);
    chk("t1_dv_count",  dv_count - d0, 2 + CRC_EXTRA);
    chk("t1_log0", {24'd0, tx_log[d0]},     32'hA5);
    chk("t1_log1", {24'd0, tx_log[d0 + 1]}, 32'h3C);
`ifdef UART_ARB_CRC_EN
    chk("t1_crc", {24'd0, tx_log[d0 + 2]}, 32'hED);
`endif

    // ---- T2: req1 and req2 together -> 1 then 2; then req0 beats req1 ----
    i_Req_Valid[1] = 1'b1; i_Req_Data[15:8]  = 8'h11; i_Req_Last[1] = 1'b1;
    i_Req_Valid[2] = 1'b1; i_Req_Data[23:16] = 8'h22; i_Req_Last[2] = 1'b1;
    tick();
    chk("t2_grant_r1", {28'd0, o_Grant}, 32'h2);
    send_byte(1, 8'h11, 1'b1, "t2_r1");
    wait_idle("t2_a");
    tick();
    chk("t2_grant_r2", {28'd0, o_Grant}, 32'h4);
    send_byte(2, 8'h22, 1'b1, "t2_r2");
    i_Req_Valid[0] = 1'b1; i_Req_Data[7:0]  = 8'h33; i_Req_Last[0] = 1'b1;
    i_Req_Valid[1] = 1'b1; i_Req_Data[15:8] = 8'h44; i_Req_Last[1] = 1'b1;
    tick();
    chk("t2_others_ignored", {28'd0, o_Grant}, 32'h4);
    chk("t2_others_ready",   {28'd0, o_Req_Ready}, 32'd0);
    wait_idle("t2_b");
    tick();
    chk("t2_grant_r0", {28'd0, o_Grant}, 32'h1);
    send_byte(0, 8'h33, 1'b1, "t2_r0");
    wait_idle("t2_c");
    tick();
    chk("t2_grant_r1b", {28'd0, o_Grant}, 32'h2);
    send_byte(1, 8'h44, 1'b1, "t2_r1b");
    wait_idle("t2_d");

    // ---- T3: 3-byte frame, done held 2 clocks per byte ----
    d0 = dv_count;
    send_byte(2, 8'h10, 1'b0, "t3_b0");
    send_byte(2, 8'h20, 1'b0, "t3_b1");
    send_byte(2, 8'h30, 1'b1, "t3_b2");
    wait_idle("t3");
    chk("t3_dv_count", dv_count - d0, 3 + CRC_EXTRA);

    // ---- T4: req3 stalls after one non-last byte ----
    send_byte(3, 8'h5A, 1'b0, "t4_b0");
    dvb = dv_count;
    n = 0;
    while (!o_Req_Ready[3] && n < 200) begin
      tick();
      n++;
    end
    n = 0;
    while (!o_Abort && n < 2000) begin
      if (o_Req_Ready[3]) n++;
      tick();
    end
    chk("t4_stall_len", n, 32'd1024);
    chk("t4_abort",     {31'd0, o_Abort}, 32'd1);
    chk("t4_grant",     {28'd0, o_Grant}, 32'h8);
    chk("t4_de_guard",  {31'd0, o_DE}, 32'd1);
    n = 0;
    while (o_DE && n < 100) begin
      tick();
      n++;
      if (n == 1) chk("t4_abort_pulse", {31'd0, o_Abort}, 32'd0);
    end
    chk("t4_guard_len",  n, 32'd16);
    chk("t4_grant_rel",  {28'd0, o_Grant}, 32'd0);
    chk("t4_no_more_dv", dv_count, dvb);

    // ---- T5: reset in WAIT while the transmitter is mid-byte ----
    send_byte(0, 8'h77, 1'b0, "t5_b0");
    tick();
    tick();
    i_Reset = 1'b1;
    #1;
    chk("t5_rst_grant", {28'd0, o_Grant}, 32'd0);
    chk("t5_rst_de",    {31'd0, o_DE}, 32'd0);
    chk("t5_rst_busy",  {31'd0, o_Busy}, 32'd0);
    chk("t5_rst_byte",  {24'd0, o_Tx_Byte}, 32'd0);
    tick();
    i_Reset = 1'b0;
    chk("t5_active_still", {31'd0, i_Tx_Active}, 32'd1);
    dvb = dv_count;
    i_Req_Valid[1] = 1'b1; i_Req_Data[15:8] = 8'h99; i_Req_Last[1] = 1'b1;
    n = 0;
    while (i_Tx_Active && n < 100) begin
      tick();
      n++;
    end
    chk("t5_no_dv_while_active", dv_count, dvb);
    chk("t5_grant_r1", {28'd0, o_Grant}, 32'h2);
    send_byte(1, 8'h99, 1'b1, "t5_b1");
    wait_idle("t5");

    // ---- T6: single-byte frame {01}; with CRC the trailer is 07 ----
    d0 = dv_count;
    send_byte(2, 8'h01, 1'b1, "t6_b0");
    wait_idle("t6");
    chk("t6_dv_count", dv_count - d0, 1 + CRC_EXTRA);
`ifdef UART_ARB_CRC_EN
    chk("t6_crc", {24'd0, tx_log[d0 + 1]}, 32'h07);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (8N1, 1-byte valid-pulse / done-pulse interface) between NUM_REQ frame sources on the motor board. Round-robin arbitration at frame granularity: a granted requester owns the line until its last byte completes, then a guard gap follows. The block sequences byte hand-off to the transmitter and drives the RS485 driver enable across the whole frame plus the guard gap.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GUARD_CLKS, 16, idle clocks after a frame's final stop bit before the grant is released
STALL_CLKS, 1024, clocks a granted requester may withhold its next byte before the frame is aborted

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  reset, asynchronous, active-high
i_Req_Valid  in  NUM_REQ  per-requester byte valid
i_Req_Data  in  8*NUM_REQ  requester k byte at [8k+7:8k]
i_Req_Last  in  NUM_REQ  marks the final byte of a frame
o_Req_Ready  out  NUM_REQ  byte accepted; at most one bit high
o_Grant  out  NUM_REQ  one-hot current owner; 0 when idle
o_Tx_DV  out  1  one-cycle start pulse to the transmitter
o_Tx_Byte  out  8  byte to the transmitter
i_Tx_Active  in  1  transmitter busy
i_Tx_Done  in  1  transmitter done (may stay high for 2 cycles)
o_DE  out  1  RS485 driver enable
o_Busy  out  1  high whenever state != IDLE
o_Abort  out  1  one-cycle pulse when a frame is aborted on stall

Behaviour:
- Reset (async assert): state=IDLE; o_Grant, o_Req_Ready, o_Tx_DV, o_Tx_Byte, o_DE, o_Busy, o_Abort = 0; RR pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, SEND, WAIT, GUARD (plus CRC, see below).
- IDLE: if any i_Req_Valid, pick the first valid index scanning from pointer+1 modulo NUM_REQ. Register o_Grant, pointer<=winner, o_DE<=1, go to SEND. Otherwise stay.
- SEND: o_Req_Ready[g] = (state==SEND) & !i_Tx_Active (combinational). A transfer happens when valid & ready are both high. Next cycle: o_Tx_DV=1 for exactly 1 cycle, o_Tx_Byte=data (held until the next transfer), last flag latched, go to WAIT. Latency from valid in IDLE to o_Tx_DV is 2 cycles.
- SEND stall: the stall counter counts cycles without a transfer. At STALL_CLKS, pulse o_Abort and go to GUARD.
- WAIT: act only on the rising edge of i_Tx_Done (previous value registered). On that edge go to SEND if the latched last flag = 0, otherwise go to GUARD. Level-high done must not count twice.
- GUARD: count GUARD_CLKS cycles with o_DE=1. Then o_Grant=0, o_DE=0, go to IDLE. New requests wait.
- Other requesters' valids are ignored while a grant is held. Non-granted o_Req_Ready bits are always 0.
- Single-requester case: back-to-back frames are still separated by GUARD.
- Reset mid-frame: immediate return to the reset state. The transmitter may still be mid-byte; SEND's !i_Tx_Active gating prevents a new DV until it finishes.
- Counters are sized ceil(log2(max+1)) with no wrap: the guard counter saturates and the stall counter clears on every transfer.

Optional Feature:
UART_ARB_CRC_EN: when defined, a CRC-8 (poly 0x07, init 0x00, MSB-first) is accumulated over every accepted byte of the frame.
- After the done edge of the last byte, state CRC issues the CRC byte via o_Tx_DV, waits for its done edge, then goes to GUARD.
- The CRC clears at grant. No CRC byte is sent on an abort.
- When undefined: no CRC state or logic; the last byte's done edge goes directly to GUARD.

Decomposition:
- Shared package uart_arb_pkg: state encodings, CRC8_POLY=8'h07, CRC8_INIT=8'h00, crc8 byte-update function.
- One sub-module, uart_arb_rr: combinational round-robin picker (valid vector + pointer -> one-hot winner + index).

Test Plan:
- Req0 sends frame {0xA5, 0x3C (last)} -> o_Tx_DV pulses twice, bytes 0xA5 then 0x3C. o_DE high from grant to 16 clocks after the 2nd done edge. o_Grant=0001 throughout.
- Req1 and Req2 valid in the same IDLE cycle after reset -> Req1 granted first. After its frame + guard, Req2 granted. Then Req0 requests and wins over Req1 re-requesting.
- Transmitter model holds i_Tx_Done high 2 cycles per byte -> exactly one byte advance per done, no skipped bytes.
- Req3 sends one byte without last, then drops valid -> o_Abort pulses at stall cycle 1024, guard follows, grant released, no further DV.
- i_Reset asserted mid-WAIT -> all outputs 0 asynchronously. After release with i_Tx_Active still high, no o_Tx_DV until it falls.
- With UART_ARB_CRC_EN, frame {0x01 (last)} -> transmitted bytes 0x01, then 0x07, then guard.
